// File: rtl/instr_data_mem_hs.sv
// Word-addressed data memory with a req/busy/ready handshake, programmable wait states
// and RV32I byte/half/word load-store semantics with misalignment/illegal-size error reporting.
module instr_data_mem_hs #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        funct3,
  input  logic [31:0]       wd,
  output logic              busy,
  output logic              ready,
  output logic [31:0]       rd,
  output logic              err
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  typedef struct packed {
    logic             we;
    logic [1:0]       off;
    logic [IDX_W-1:0] idx;
    logic [2:0]       f3;
    logic [31:0]      wd;
    logic             bad;
  } req_t;

  state_t      state, state_nx;
  logic [2:0]  cnt;
  req_t        r;
  logic [31:0] mem [DEPTH_WORDS];

  // Reset asserts asynchronously, releases two clocks later in step with clk.
  logic [1:0] rst_sync;
  logic       rst_i;
  always_ff @(posedge clk or negedge rst)
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  assign rst_i = rst_sync[1];

  generate
    if (ADDR_W > IDX_W + 2) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^addr[ADDR_W-1:IDX_W+2];
    end
  endgenerate

  // Request classification, evaluated on the raw inputs at acceptance.
  logic illegal, misaligned;
  always_comb begin
    illegal    = we ? (funct3[2] || funct3[1:0] == 2'b11)
                    : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    misaligned = (funct3[1:0] == 2'b01 && addr[0]) ||
                 (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst_i)
    if (!rst_i) state <= S_IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (req) state_nx = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (cnt == 3'd1) state_nx = S_ACCESS;
      S_ACCESS: state_nx = S_RESP;
      S_RESP:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != S_IDLE);
    ready = (state == S_RESP);
    err   = (state == S_RESP) && r.bad;
  end

  // Store lane data and byte enables.
  logic [31:0] wdata;
  logic [3:0]  be;
  always_comb begin
    case (r.f3[1:0])
      2'b00:   begin wdata = {4{r.wd[7:0]}};  be = 4'b0001 << r.off; end
      2'b01:   begin wdata = {2{r.wd[15:0]}}; be = r.off[1] ? 4'b1100 : 4'b0011; end
      default: begin wdata = r.wd;            be = 4'b1111; end
    endcase
  end

  // Load extraction and extension.
  logic [31:0] word, ld;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  always_comb begin
    word = mem[r.idx];
    ld_b = word[8*r.off +: 8];
    ld_h = word[16*r.off[1] +: 16];
    case (r.f3)
      3'b000:  ld = {{24{ld_b[7]}}, ld_b};
      3'b100:  ld = {24'h0, ld_b};
      3'b001:  ld = {{16{ld_h[15]}}, ld_h};
      3'b101:  ld = {16'h0, ld_h};
      default: ld = word;
    endcase
  end

  always_ff @(posedge clk or negedge rst_i)
    if (!rst_i) begin
      cnt <= '0;
      r   <= '0;
      rd  <= '0;
    end else begin
      case (state)
        S_IDLE:   if (req) begin
                    r   <= '{we: we, off: addr[1:0], idx: addr[2 +: IDX_W], f3: funct3,
                             wd: wd, bad: illegal || misaligned};
                    cnt <= 3'(WAIT_STATES);
                  end
        S_WAIT:   cnt <= cnt - 3'd1;
        S_ACCESS: if (!r.we && !r.bad) rd <= ld;
        default:  ;
      endcase
    end

  // Array has no reset; contents survive rst.
  always_ff @(posedge clk)
    if (state == S_ACCESS && r.we && !r.bad)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[r.idx][8*i +: 8] <= wdata[8*i +: 8];

endmodule

// File: tb/tb_instr_data_mem_hs.sv
// Directed self-checking bench for instr_data_mem_hs (WAIT_STATES=2, DEPTH_WORDS=1024).
module tb_instr_data_mem_hs;
  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] wd = '0;
  logic        busy, ready, err;
  logic [31:0] rd;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  instr_data_mem_hs #(.DEPTH_WORDS(1024), .WAIT_STATES(WS), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .funct3(funct3), .wd(wd),
    .busy(busy), .ready(ready), .rd(rd), .err(err)
  );

  // Issues one request when idle; lat = negedges after the accepting edge until ready (-1 on timeout).
  task automatic do_acc(input logic w, input logic [31:0] a, input logic [2:0] f,
                        input logic [31:0] d, output logic [31:0] o_rd, output logic o_err,
                        output int lat);
    int guard;
    lat = -1; o_rd = 'x; o_err = 1'bx;
    @(negedge clk);
    guard = 0;
    while (busy && guard < 20) begin @(negedge clk); guard++; end
    req = 1'b1; we = w; addr = a; funct3 = f; wd = d;
    @(posedge clk); #1 req = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ready) begin lat = n; o_rd = rd; o_err = err; break; end
    end
  endtask

  task automatic test_reset;
    #12;
    n_chk++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (ready !== 1'b0)  begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_chk++; if (err !== 1'b0)    begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_chk++; if (rd !== 32'h0)    begin n_fail++; $display("FAIL reset_rd: got %h want 0", rd); end
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_store_load;
    logic [31:0] o; logic e; int l;
    do_acc(1, 32'h10, 3'b010, 32'hDEADBEEF, o, e, l);
    n_chk++; if (l !== WS + 2)     begin n_fail++; $display("FAIL sw_latency: got %0d want %0d", l, WS + 2); end
    n_chk++; if (e !== 1'b0)       begin n_fail++; $display("FAIL sw_err: got %b want 0", e); end
    n_chk++; if (o !== 32'h0)      begin n_fail++; $display("FAIL sw_rd_hold: got %h want 0", o); end
    do_acc(0, 32'h10, 3'b010, 32'h0, o, e, l);
    n_chk++; if (l !== WS + 2)     begin n_fail++; $display("FAIL lw_latency: got %0d want %0d", l, WS + 2); end
    n_chk++; if (o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rd: got %h want deadbeef", o); end
    n_chk++; if (e !== 1'b0)       begin n_fail++; $display("FAIL lw_err: got %b want 0", e); end
  endtask

  task automatic test_subword;
    logic [31:0] o; logic e; int l;
    do_acc(1, 32'h11, 3'b000, 32'h80, o, e, l);
    n_chk++; if (o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sb_rd_hold: got %h want deadbeef", o); end
    do_acc(0, 32'h11, 3'b000, 32'h0, o, e, l);
    n_chk++; if (o !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb: got %h want ffffff80", o); end
    do_acc(0, 32'h11, 3'b100, 32'h0, o, e, l);
    n_chk++; if (o !== 32'h00000080) begin n_fail++; $display("FAIL lbu: got %h want 00000080", o); end
    do_acc(0, 32'h10, 3'b010, 32'h0, o, e, l);
    n_chk++; if (o !== 32'hDEAD80EF) begin n_fail++; $display("FAIL lw_after_sb: got %h want dead80ef", o); end
    do_acc(0, 32'h10, 3'b001, 32'h0, o, e, l);
    n_chk++; if (o !== 32'hFFFF80EF) begin n_fail++; $display("FAIL lh: got %h want ffff80ef", o); end
    do_acc(0, 32'h12, 3'b101, 32'h0, o, e, l);
    n_chk++; if (o !== 32'h0000DEAD) begin n_fail++; $display("FAIL lhu: got %h want 0000dead", o); end
  endtask

  task automatic test_errors;
    logic [31:0] o; logic e; int l;
    do_acc(0, 32'h13, 3'b001, 32'h0, o, e, l);
    n_chk++; if (e !== 1'b1)       begin n_fail++; $display("FAIL lh_misaligned_err: got %b want 1", e); end
    n_chk++; if (o !== 32'h0000DEAD) begin n_fail++; $display("FAIL lh_misaligned_rd: got %h want 0000dead", o); end
    n_chk++; if (l !== WS + 2)     begin n_fail++; $display("FAIL err_latency: got %0d want %0d", l, WS + 2); end
    do_acc(1, 32'h12, 3'b010, 32'h55555555, o, e, l);
    n_chk++; if (e !== 1'b1)       begin n_fail++; $display("FAIL sw_misaligned_err: got %b want 1", e); end
    n_chk++; if (o !== 32'h0000DEAD) begin n_fail++; $display("FAIL sw_misaligned_rd: got %h want 0000dead", o); end
    do_acc(0, 32'h10, 3'b011, 32'h0, o, e, l);
    n_chk++; if (e !== 1'b1)       begin n_fail++; $display("FAIL load_illegal_err: got %b want 1", e); end
    do_acc(1, 32'h10, 3'b100, 32'hFF, o, e, l);
    n_chk++; if (e !== 1'b1)       begin n_fail++; $display("FAIL store_illegal_err: got %b want 1", e); end
    n_chk++; if (err !== 1'b0)     begin @(negedge clk); end
    if (err !== 1'b0)              begin n_fail++; $display("FAIL err_after_ready: got %b want 0", err); end
    do_acc(0, 32'h10, 3'b010, 32'h0, o, e, l);
    n_chk++; if (o !== 32'hDEAD80EF) begin n_fail++; $display("FAIL lw_after_errors: got %h want dead80ef", o); end
    n_chk++; if (e !== 1'b0)       begin n_fail++; $display("FAIL lw_after_errors_err: got %b want 0", e); end
  endtask

  task automatic test_wrap;
    logic [31:0] o; logic e; int l;
    do_acc(1, 32'h1010, 3'b010, 32'h12345678, o, e, l);
    do_acc(0, 32'h10, 3'b010, 32'h0, o, e, l);
    n_chk++; if (o !== 32'h12345678) begin n_fail++; $display("FAIL addr_wrap: got %h want 12345678", o); end
    do_acc(1, 32'h12, 3'b001, 32'hFFFFABCD, o, e, l);
    do_acc(0, 32'h10, 3'b010, 32'h0, o, e, l);
    n_chk++; if (o !== 32'hABCD5678) begin n_fail++; $display("FAIL sh_upper: got %h want abcd5678", o); end
  endtask

  task automatic test_back_to_back;
    int acc_n = 0, rdy_n = 0, acc_first = -1, acc_second = -1, guard = 0;
    @(negedge clk);
    while (busy && guard < 20) begin @(negedge clk); guard++; end
    req = 1'b1; we = 1'b0; addr = 32'h10; funct3 = 3'b010;
    for (int k = 0; k < 10; k++) begin
      if (!busy) begin
        acc_n++;
        if (acc_first < 0) acc_first = k; else if (acc_second < 0) acc_second = k;
      end
      if (ready) rdy_n++;
      @(posedge clk);
      @(negedge clk);
    end
    req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (ready) rdy_n++;
      @(negedge clk);
    end
    n_chk++; if (acc_n !== 2)      begin n_fail++; $display("FAIL b2b_accepts: got %0d want 2", acc_n); end
    n_chk++; if (acc_second - acc_first !== WS + 3)
      begin n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", acc_second - acc_first, WS + 3); end
    n_chk++; if (rdy_n !== 2)      begin n_fail++; $display("FAIL b2b_ready_count: got %0d want 2", rdy_n); end
    n_chk++; if (rd !== 32'hABCD5678) begin n_fail++; $display("FAIL b2b_rd: got %h want abcd5678", rd); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] o; logic e; int l, guard;
    do_acc(1, 32'h20, 3'b010, 32'hCAFEF00D, o, e, l);
    @(negedge clk);
    guard = 0;
    while (busy && guard < 20) begin @(negedge clk); guard++; end
    req = 1'b1; we = 1'b1; addr = 32'h20; funct3 = 3'b010; wd = 32'h1;
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    n_chk++; if (busy !== 1'b1)    begin n_fail++; $display("FAIL abort_in_wait_busy: got %b want 1", busy); end
    rst = 1'b0; #1;
    n_chk++; if ({busy, ready, err} !== 3'b000)
      begin n_fail++; $display("FAIL abort_ctrl_zero: got %b want 000", {busy, ready, err}); end
    n_chk++; if (rd !== 32'h0)     begin n_fail++; $display("FAIL abort_rd_zero: got %h want 0", rd); end
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    do_acc(0, 32'h20, 3'b010, 32'h0, o, e, l);
    n_chk++; if (o !== 32'hCAFEF00D) begin n_fail++; $display("FAIL abort_no_write: got %h want cafef00d", o); end
    n_chk++; if (l !== WS + 2)     begin n_fail++; $display("FAIL abort_latency: got %0d want %0d", l, WS + 2); end
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_subword;
    test_errors;
    test_wrap;
    test_back_to_back;
    test_reset_abort;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
